// File: rtl/cipher_letter_buffer.sv
// rtl/cipher_letter_buffer.sv - first-word-fall-through letter FIFO with out-of-range code detection
module cipher_letter_buffer #(
  parameter int DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] in_letter,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       clear,
  output logic [4:0] out_letter,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] count,
  output logic       invalid_seen
);

  localparam int         AW         = $clog2(DEPTH);
  localparam logic [6:0] FULL_COUNT = 7'(DEPTH);
  localparam logic [4:0] LAST_CODE  = 5'd25;

  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [6:0]    count_q;
  logic [6:0]    count_d;
  logic          invalid_q;
  logic          push_fire;
  logic          push_store;
  logic          push_bad;
  logic          pop_fire;

  // Handshake flags depend only on the stored count, never on the peer's strobes.
  assign in_ready     = (count_q < FULL_COUNT);
  assign out_valid    = (count_q != 7'd0);
  assign out_letter   = out_valid ? mem[rd_ptr] : 5'd0;
  assign count        = count_q;
  assign invalid_seen = invalid_q;

  // An accepted out-of-range code completes the handshake but is never written.
  assign push_fire  = in_valid & in_ready;
  assign push_store = push_fire & (in_letter <= LAST_CODE);
  assign push_bad   = push_fire & (in_letter > LAST_CODE);
  assign pop_fire   = out_valid & out_ready;

  // Next occupancy: +1 push only, -1 pop only, unchanged for both or neither.
  always_comb begin
    count_d = count_q;
    if (push_store && !pop_fire) begin
      count_d = count_q + 7'd1;
    end else if (pop_fire && !push_store) begin
      count_d = count_q - 7'd1;
    end
  end

  // Pointer, occupancy and sticky error state; clear takes priority over any transfer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= 7'd0;
      invalid_q <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= 7'd0;
      invalid_q <= 1'b0;
    end else begin
      if (push_store) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_bad) begin
        invalid_q <= 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Letter storage carries no reset; entries are only read while counted as valid.
  always_ff @(posedge clock) begin
    if (push_store && !clear) begin
      mem[wr_ptr] <= in_letter;
    end
  end

endmodule

// File: tb/tb_cipher_letter_buffer.sv
// tb/tb_cipher_letter_buffer.sv - directed self-checking bench for cipher_letter_buffer
module tb_cipher_letter_buffer;

  logic       clock;
  logic       reset;
  logic [4:0] in_letter;
  logic       in_valid;
  logic       in_ready;
  logic       clear;
  logic [4:0] out_letter;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] count;
  logic       invalid_seen;

  int n_checks;
  int n_fail;

  cipher_letter_buffer #(.DEPTH(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_letter   (in_letter),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .clear       (clear),
    .out_letter  (out_letter),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .invalid_seen(invalid_seen)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [4:0] letter);
    in_valid  = 1'b1;
    in_letter = letter;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic check_state(input string tag, input int exp_count, input int exp_valid,
                             input int exp_letter, input int exp_ready);
    check({tag, ".count"},      32'(count),      exp_count);
    check({tag, ".out_valid"},  32'(out_valid),  exp_valid);
    check({tag, ".out_letter"}, 32'(out_letter), exp_letter);
    check({tag, ".in_ready"},   32'(in_ready),   exp_ready);
  endtask

  logic [4:0] exp_q[$];
  int         n_out;
  int         guard;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_letter = 5'd0;
    out_ready = 1'b0;

    // Reset state
    step();
    step();
    check_state("reset", 0, 0, 0, 1);
    check("reset.invalid", 32'(invalid_seen), 0);
    reset = 1'b1;
    step();

    // H, E, L buffered then drained in order
    push(5'd7);
    check_state("fwft", 1, 1, 7, 1);
    push(5'd4);
    push(5'd11);
    check_state("hel_fill", 3, 1, 7, 1);
    out_ready = 1'b1;
    check("hel_pop0", 32'(out_letter), 7);
    step();
    check("hel_pop1", 32'(out_letter), 4);
    step();
    check("hel_pop2", 32'(out_letter), 11);
    step();
    out_ready = 1'b0;
    check_state("hel_empty", 0, 0, 0, 1);

    // Fill to DEPTH, then offer while full with a pop in the same cycle
    for (int i = 0; i < 16; i++) push(5'(i));
    check_state("full", 16, 1, 0, 0);
    in_valid  = 1'b1;
    in_letter = 5'd20;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    check_state("full_pop", 15, 1, 1, 1);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("full_drain%0d", i), 32'(out_letter), i);
      step();
    end
    out_ready = 1'b0;
    check_state("full_drained", 0, 0, 0, 1);

    // Stream 44 letters through with concurrent push/pop; pointers wrap repeatedly
    exp_q.delete();
    n_out = 0;
    for (int i = 0; i < 44; i++) begin
      in_valid  = 1'b1;
      in_letter = 5'((i * 7 + 3) % 26);
      out_ready = (i >= 4);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("stream_underflow", 1, 0);
        else check($sformatf("stream%0d", n_out), 32'(out_letter), 32'(exp_q.pop_front()));
        n_out++;
      end
      if (in_ready) exp_q.push_back(in_letter);
      step();
    end
    in_valid = 1'b0;
    check("stream_count", 32'(count), 4);
    out_ready = 1'b1;
    guard = 0;
    while (out_valid && guard < 40) begin
      if (exp_q.size() == 0) check("stream_extra", 1, 0);
      else check($sformatf("stream%0d", n_out), 32'(out_letter), 32'(exp_q.pop_front()));
      n_out++;
      guard++;
      step();
    end
    out_ready = 1'b0;
    check("stream_total", 32'(n_out), 44);
    check("stream_empty", 32'(count), 0);

    // Out-of-range code: handshake taken, nothing stored, sticky flag
    push(5'd3);
    in_valid  = 1'b1;
    in_letter = 5'd27;
    check("bad_ready", 32'(in_ready), 1);
    step();
    in_valid  = 1'b0;
    push(5'd5);
    check("bad_flag", 32'(invalid_seen), 1);
    check("bad_count", 32'(count), 2);
    out_ready = 1'b1;
    check("bad_pop0", 32'(out_letter), 3);
    step();
    check("bad_pop1", 32'(out_letter), 5);
    step();
    out_ready = 1'b0;
    step();
    check("bad_sticky", 32'(invalid_seen), 1);
    push(5'd8);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_state("clear", 0, 0, 0, 1);
    check("clear_flag", 32'(invalid_seen), 0);

    // Clear wins over simultaneous push and pop on a non-empty buffer
    push(5'd9);
    push(5'd10);
    clear     = 1'b1;
    in_valid  = 1'b1;
    in_letter = 5'd12;
    out_ready = 1'b1;
    step();
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_state("clear_prio", 0, 0, 0, 1);
    push(5'd13);
    check_state("clear_after", 1, 1, 13, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) push(5'(i + 17));
    check("pre_reset_count", 32'(count), 5);
    #2;
    reset = 1'b0;
    #1;
    check_state("async_reset", 0, 0, 0, 1);
    #3;
    reset = 1'b1;
    step();
    push(5'd25);
    check_state("post_reset", 1, 1, 25, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
